// File: rtl/manchester_pkg.sv
// Shared constants, state encoding and FIFO word layout for the
// Manchester receive path.
package manchester_pkg;

   localparam logic [7:0] FLAG     = 8'h7E;
   localparam logic [7:0] ESC      = 8'h7D;
   localparam logic [7:0] PREAMBLE = 8'h55;
   localparam logic [7:0] ESC_XOR  = 8'h20;

   typedef enum logic [1:0] {
      HUNT,
      PAYLOAD,
      ESCAPED,
      DISCARD
   } state_e;

   typedef struct packed {
      logic       user;
      logic       last;
      logic [7:0] data;
   } fifo_word_t;

endpackage

// File: rtl/manchester_deframer_if.sv
// Byte stream in (no backpressure) and AXI-Stream payload out.
// The slave modport is the deframer's view; master is the environment's.
interface manchester_deframer_if;

   logic [7:0] s_axis_tdata;
   logic       s_axis_tvalid;
   logic [7:0] m_axis_tdata;
   logic       m_axis_tvalid;
   logic       m_axis_tready;
   logic       m_axis_tlast;
   logic       m_axis_tuser;

   modport slave (
      input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
      output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
   );

   modport master (
      output s_axis_tdata, s_axis_tvalid, m_axis_tready,
      input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
   );

endinterface

// File: rtl/axis_sync_fifo.sv
// First-word-fall-through synchronous FIFO with registered full/empty.
// A write while full is accepted only when a read happens in the same cycle.
module axis_sync_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic [AW:0]      count_d;
   logic             do_wr;
   logic             do_rd;

   assign do_rd   = rd_en && !empty;
   assign do_wr   = wr_en && (!full || do_rd);
   assign rd_data = mem[rd_ptr];

   always_comb begin
      count_d = count;
      if (do_wr && !do_rd) begin
         count_d = count + 1'b1;
      end else if (!do_wr && do_rd) begin
         count_d = count - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         count <= count_d;
         full  <= (count_d == (AW+1)'(DEPTH));
         empty <= (count_d == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/manchester_deframer.sv
// Frame hunter / unescaper turning decoded bytes into AXI-Stream packets,
// with in-band abort terminators and status pulses.
module manchester_deframer
   import manchester_pkg::*;
#(
   parameter int MAX_LEN = 256,
   parameter int DEPTH   = 16
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   manchester_deframer_if.slave        bus,
   output logic                        frame_ok,
   output logic                        frame_err,
   output logic                        overflow
);

   localparam int             LW      = $clog2(MAX_LEN + 1);
   localparam logic [LW-1:0]  LEN_MAX = LW'(MAX_LEN);

   state_e        state_q, state_d;
   logic [7:0]    hold_q, hold_d;
   logic          hold_vld_q, hold_vld_d;
   logic [LW-1:0] len_q, len_d;
   logic          in_fifo_q, in_fifo_d;
   logic          term_q, term_d;
   logic          seen_q, seen_d;
   logic          ok_d, err_d, ovf_d;

   logic          push;
   fifo_word_t    push_word;
   fifo_word_t    head;
   logic          fifo_full;
   logic          fifo_empty;
   logic          pop;
   logic          can_push;
   logic          load;
   logic [7:0]    ld_byte;
   logic          abort;
   logic          abort_seen;
   logic          v;
   logic          is_flag;
   logic          is_esc;

   assign v        = bus.s_axis_tvalid;
   assign is_flag  = bus.s_axis_tdata == FLAG;
   assign is_esc   = bus.s_axis_tdata == ESC;
   assign pop      = !fifo_empty && bus.m_axis_tready;
   assign can_push = !fifo_full || pop;

   always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      len_d      = len_q;
      in_fifo_d  = in_fifo_q;
      term_d     = term_q;
      seen_d     = seen_q;
      ok_d       = 1'b0;
      err_d      = 1'b0;
      ovf_d      = 1'b0;
      push       = 1'b0;
      push_word  = '0;
      load       = 1'b0;
      ld_byte    = '0;
      abort      = 1'b0;
      abort_seen = 1'b0;

      unique case (state_q)
         HUNT: begin
            if (v && is_flag) begin
               len_d     = '0;
               in_fifo_d = 1'b0;
               state_d   = PAYLOAD;
            end
         end
         PAYLOAD: begin
            if (v && is_flag) begin
               len_d     = '0;
               in_fifo_d = 1'b0;
               if (hold_vld_q && can_push) begin
                  push       = 1'b1;
                  push_word  = '{user: 1'b0, last: 1'b1, data: hold_q};
                  ok_d       = 1'b1;
                  hold_vld_d = 1'b0;
               end else if (hold_vld_q) begin
                  abort = 1'b1;
                  ovf_d = 1'b1;
               end
            end else if (v && is_esc) begin
               state_d = ESCAPED;
            end else if (v) begin
               load    = 1'b1;
               ld_byte = bus.s_axis_tdata;
            end
         end
         ESCAPED: begin
            if (v && is_flag) begin
               abort      = 1'b1;
               abort_seen = 1'b1;
            end else if (v) begin
               load    = 1'b1;
               ld_byte = bus.s_axis_tdata ^ ESC_XOR;
               state_d = PAYLOAD;
            end
         end
         DISCARD: begin
            // Once clean, the current byte is treated as if already in HUNT.
            if (!term_q && seen_q) begin
               state_d = HUNT;
               if (v && is_flag) begin
                  len_d     = '0;
                  in_fifo_d = 1'b0;
                  state_d   = PAYLOAD;
               end
            end else begin
               if (v && is_flag) seen_d = 1'b1;
               if (term_q && can_push) begin
                  push      = 1'b1;
                  push_word = '{user: 1'b1, last: 1'b1, data: 8'h00};
                  term_d    = 1'b0;
               end
            end
         end
         default: state_d = HUNT;
      endcase

      if (load) begin
         if (len_q == LEN_MAX) begin
            abort = 1'b1;
         end else if (hold_vld_q && !can_push) begin
            abort = 1'b1;
            ovf_d = 1'b1;
         end else begin
            if (hold_vld_q) begin
               push      = 1'b1;
               push_word = '{user: 1'b0, last: 1'b0, data: hold_q};
               in_fifo_d = 1'b1;
            end
            hold_d     = ld_byte;
            hold_vld_d = 1'b1;
            len_d      = len_q + 1'b1;
         end
      end

      if (abort) begin
         hold_vld_d = 1'b0;
         err_d      = 1'b1;
         term_d     = in_fifo_q;
         seen_d     = abort_seen;
         state_d    = DISCARD;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q    <= HUNT;
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
         len_q      <= '0;
         in_fifo_q  <= 1'b0;
         term_q     <= 1'b0;
         seen_q     <= 1'b0;
         frame_ok   <= 1'b0;
         frame_err  <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
         len_q      <= len_d;
         in_fifo_q  <= in_fifo_d;
         term_q     <= term_d;
         seen_q     <= seen_d;
         frame_ok   <= ok_d;
         frame_err  <= err_d;
         overflow   <= ovf_d;
      end
   end

   axis_sync_fifo #(
      .WIDTH (10),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (aclk),
      .rst_n   (aresetn),
      .wr_en   (push),
      .wr_data (push_word),
      .rd_en   (bus.m_axis_tready),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Memory contents are unreset, so mask the head while empty.
   assign bus.m_axis_tvalid = !fifo_empty;
   assign bus.m_axis_tdata  = fifo_empty ? 8'h00 : head.data;
   assign bus.m_axis_tlast  = !fifo_empty && head.last;
   assign bus.m_axis_tuser  = !fifo_empty && head.user;

endmodule

// File: tb/tb_manchester_deframer.sv
// Directed bench for manchester_deframer: two instances (small FIFO,
// short MAX_LEN) with an expected-output queue compared after each step.
module tb_manchester_deframer;

   logic clk = 1'b0;
   logic aresetn = 1'b0;
   always #5 clk = ~clk;

   manchester_deframer_if ia ();
   manchester_deframer_if ib ();

   logic ok_a, err_a, ovf_a;
   logic ok_b, err_b, ovf_b;

   manchester_deframer #(.MAX_LEN(256), .DEPTH(4)) dut_a (
      .aclk      (clk),
      .aresetn   (aresetn),
      .bus       (ia.slave),
      .frame_ok  (ok_a),
      .frame_err (err_a),
      .overflow  (ovf_a)
   );

   manchester_deframer #(.MAX_LEN(2), .DEPTH(16)) dut_b (
      .aclk      (clk),
      .aresetn   (aresetn),
      .bus       (ib.slave),
      .frame_ok  (ok_b),
      .frame_err (err_b),
      .overflow  (ovf_b)
   );

   logic [9:0] rx [2][64];
   int         rx_n [2];
   int         n_ok [2];
   int         n_err [2];
   int         n_ovf [2];

   always @(negedge clk) begin
      if (aresetn) begin
         if (ia.m_axis_tvalid && ia.m_axis_tready) begin
            rx[0][rx_n[0][5:0]] <= {ia.m_axis_tuser, ia.m_axis_tlast, ia.m_axis_tdata};
            rx_n[0] <= rx_n[0] + 1;
         end
         if (ib.m_axis_tvalid && ib.m_axis_tready) begin
            rx[1][rx_n[1][5:0]] <= {ib.m_axis_tuser, ib.m_axis_tlast, ib.m_axis_tdata};
            rx_n[1] <= rx_n[1] + 1;
         end
         n_ok[0]  <= n_ok[0]  + (ok_a  ? 1 : 0);
         n_err[0] <= n_err[0] + (err_a ? 1 : 0);
         n_ovf[0] <= n_ovf[0] + (ovf_a ? 1 : 0);
         n_ok[1]  <= n_ok[1]  + (ok_b  ? 1 : 0);
         n_err[1] <= n_err[1] + (err_b ? 1 : 0);
         n_ovf[1] <= n_ovf[1] + (ovf_b ? 1 : 0);
      end
   end

   int         errors = 0;
   int         checks = 0;
   int         rd [2];
   int         b_ok, b_err, b_ovf;
   logic [7:0] seq [$];
   logic [9:0] expq [$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic send_seq(input int sel);
      for (int i = 0; i < seq.size(); i++) begin
         @(posedge clk); #1;
         if (sel == 0) begin
            ia.s_axis_tdata  = seq[i];
            ia.s_axis_tvalid = 1'b1;
         end else begin
            ib.s_axis_tdata  = seq[i];
            ib.s_axis_tvalid = 1'b1;
         end
      end
      @(posedge clk); #1;
      ia.s_axis_tvalid = 1'b0;
      ib.s_axis_tvalid = 1'b0;
   endtask

   task automatic snap(input int sel);
      b_ok  = n_ok[sel];
      b_err = n_err[sel];
      b_ovf = n_ovf[sel];
   endtask

   task automatic drain(input string tag, input int sel);
      logic [9:0] got;
      logic [9:0] exp;
      for (int i = 0; i < 200; i++) begin
         if (rx_n[sel] - rd[sel] >= expq.size()) break;
         @(posedge clk);
      end
      repeat (4) @(posedge clk);
      while (expq.size() > 0) begin
         exp = expq.pop_front();
         got = 'x;
         if (rd[sel] < rx_n[sel]) begin
            got = rx[sel][rd[sel]];
            rd[sel]++;
         end
         chk({tag, "_out"}, 32'(got), 32'(exp));
      end
      chk({tag, "_extra"}, rx_n[sel] - rd[sel], 0);
      rd[sel] = rx_n[sel];
   endtask

   task automatic pulses(input string tag, input int sel,
                         input int eok, input int eerr, input int eovf);
      chk({tag, "_ok"},  n_ok[sel]  - b_ok,  eok);
      chk({tag, "_err"}, n_err[sel] - b_err, eerr);
      chk({tag, "_ovf"}, n_ovf[sel] - b_ovf, eovf);
   endtask

   initial begin
      ia.s_axis_tdata  = '0;
      ia.s_axis_tvalid = 1'b0;
      ia.m_axis_tready = 1'b1;
      ib.s_axis_tdata  = '0;
      ib.s_axis_tvalid = 1'b0;
      ib.m_axis_tready = 1'b1;

      repeat (3) @(negedge clk);
      chk("rst_a", {ia.m_axis_tvalid, ia.m_axis_tdata, ia.m_axis_tlast,
                    ia.m_axis_tuser, ok_a, err_a, ovf_a}, 0);
      chk("rst_b", {ib.m_axis_tvalid, ib.m_axis_tdata, ib.m_axis_tlast,
                    ib.m_axis_tuser, ok_b, err_b, ovf_b}, 0);
      @(posedge clk); #1;
      aresetn = 1'b1;

      // Clean frame behind preamble
      snap(0);
      seq  = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h7E, 8'h01, 8'h02, 8'h03, 8'h7E};
      expq = '{10'h001, 10'h002, 10'h103};
      send_seq(0);
      drain("clean", 0);
      pulses("clean", 0, 1, 0, 0);

      // Escaped FLAG and ESC bytes
      snap(0);
      seq  = '{8'h7E, 8'h7D, 8'h5E, 8'h7D, 8'h5D, 8'h7E};
      expq = '{10'h07E, 10'h17D};
      send_seq(0);
      drain("esc", 0);
      pulses("esc", 0, 1, 0, 0);

      // ESC+FLAG abort, then a good frame
      snap(0);
      seq  = '{8'h7E, 8'h11, 8'h22, 8'h7D, 8'h7E, 8'h55, 8'h7E, 8'h33, 8'h7E};
      expq = '{10'h011, 10'h300, 10'h133};
      send_seq(0);
      drain("escabort", 0);
      pulses("escabort", 0, 1, 1, 0);

      // Overflow with a stalled consumer and a 4-entry FIFO
      snap(0);
      ia.m_axis_tready = 1'b0;
      seq  = '{8'h7E, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h7E};
      expq = '{10'h001, 10'h002, 10'h003, 10'h004, 10'h300};
      send_seq(0);
      repeat (3) @(negedge clk);
      chk("stall_head1", {ia.m_axis_tvalid, ia.m_axis_tuser, ia.m_axis_tlast,
                          ia.m_axis_tdata}, {1'b1, 2'b00, 8'h01});
      repeat (2) @(negedge clk);
      chk("stall_head2", {ia.m_axis_tvalid, ia.m_axis_tuser, ia.m_axis_tlast,
                          ia.m_axis_tdata}, {1'b1, 2'b00, 8'h01});
      @(posedge clk); #1;
      ia.m_axis_tready = 1'b1;
      drain("ovf", 0);
      seq  = '{8'h7E, 8'hAA, 8'h7E};
      expq = '{10'h1AA};
      send_seq(0);
      drain("ovf_next", 0);
      pulses("ovf", 0, 1, 1, 1);

      // Length limit and empty frames on the MAX_LEN=2 instance
      snap(1);
      seq  = '{8'h7E, 8'h7E, 8'h7E, 8'h01, 8'h02, 8'h03, 8'h7E, 8'h7E,
               8'h09, 8'h7E};
      expq = '{10'h001, 10'h300, 10'h109};
      send_seq(1);
      drain("len", 1);
      pulses("len", 1, 1, 1, 0);

      // Reset in the middle of a frame
      snap(0);
      seq  = '{8'h7E, 8'h01, 8'h02};
      send_seq(0);
      aresetn = 1'b0;
      repeat (3) @(negedge clk);
      chk("midrst", {ia.m_axis_tvalid, ia.m_axis_tdata, ia.m_axis_tlast,
                     ia.m_axis_tuser, ok_a, err_a, ovf_a}, 0);
      @(posedge clk); #1;
      aresetn = 1'b1;
      repeat (2) @(negedge clk);
      chk("midrst_empty", 32'(ia.m_axis_tvalid), 0);
      seq  = '{8'h7E, 8'h05, 8'h7E};
      expq = '{10'h105};
      send_seq(0);
      drain("midrst", 0);
      pulses("midrst", 0, 1, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/manchester_deframer.md
# manchester_deframer

Receive-side byte deframer sitting directly downstream of `manchester_decoder`. It takes the decoder's free-running byte stream, which has no backpressure, and hunts for frame start. It strips preamble and delimiter bytes, undoes byte escaping, and delivers each payload as an AXI-Stream packet with `tlast`. A small FIFO absorbs consumer stalls, and every abnormal frame end is reported in-band and on pulse outputs.

## Interface
- `FLAG`, 8'h7E: start/end delimiter.
- `ESC`, 8'h7D: escape prefix. The escaped byte is transmitted as `b ^ 8'h20`.
- `PREAMBLE`, 8'h55: idle/preamble byte.
- `MAX_LEN`, 256: maximum payload bytes per frame.
- `DEPTH`, 16: output FIFO entries (power of two, ≥4).
- `aclk` in 1: clock.
- `aresetn` in 1: reset, asynchronous, active-low.
- `s_axis_tdata` in 8: decoded byte.
- `s_axis_tvalid` in 1: byte strobe. There is no `tready`; every strobe is consumed.
- `m_axis_tdata` out 8: payload byte.
- `m_axis_tvalid` out 1: output valid.
- `m_axis_tready` in 1: consumer ready.
- `m_axis_tlast` out 1: last byte of frame.
- `m_axis_tuser` out 1: set together with `tlast` to mark an aborted frame.
- `frame_ok` out 1: one-cycle pulse, good frame committed.
- `frame_err` out 1: one-cycle pulse, frame aborted.
- `overflow` out 1: one-cycle pulse, byte lost because the FIFO was full.

## Operation
- **States:** HUNT, PAYLOAD, ESCAPED, DISCARD. Reset state is HUNT.
- **HUNT:** all bytes ignored except `FLAG`. `FLAG` resets the length counter and moves to PAYLOAD.
- **PAYLOAD:**
  - A data byte loads the 1-byte hold register. If the hold register was full, its old byte is written to the FIFO first with `last=0`.
  - `ESC` moves to ESCAPED.
  - `FLAG` with a full hold register writes the held byte with `last=1, user=0`, pulses `frame_ok` and stays in PAYLOAD (shared flag).
  - `FLAG` with an empty hold register means an empty frame: dropped silently, stays in PAYLOAD.
- **ESCAPED:** byte `b` is loaded as `b ^ 8'h20` (same path as a PAYLOAD data byte), then back to PAYLOAD. `FLAG` here triggers an abort.
- **Abort triggers:**
  - `ESC` followed by `FLAG`.
  - Payload length would exceed `MAX_LEN`.
  - FIFO write needed while the FIFO is full (also pulses `overflow`).
- **Abort actions:**
  - Held byte discarded.
  - `frame_err` pulses.
  - If at least one byte of this frame already entered the FIFO, a terminator `{data 8'h00, last 1, user 1}` becomes pending.
  - Enter DISCARD.
- **DISCARD:**
  - The pending terminator is written on the first cycle the FIFO is not full. It is never written after a later frame's bytes.
  - Exit to HUNT when the terminator is no longer pending and a `FLAG` has been seen since the abort. The abort-causing `FLAG` of ESC+FLAG counts as seen.
- **Length counter:** `$clog2(MAX_LEN+1)` bits, saturating, cleared on every `FLAG` accepted in PAYLOAD/HUNT.
- **`PREAMBLE` handling:** `PREAMBLE` bytes inside a frame are payload. They carry meaning only in HUNT, where they are ignored anyway.

## Timing
- Reset values: all outputs 0, FIFO empty, hold register empty, pending terminator clear.
- Reset asserted mid-frame drops all state immediately; nothing is emitted afterwards.
- FIFO is first-word-fall-through with registered flags. An entry written in cycle k drives `m_axis_tvalid` from k+1.
- Latency: payload byte i becomes visible 1 cycle after byte i+1, or after the closing `FLAG`, is accepted.
- AXI-Stream rules:
  - `tdata/tlast/tuser` are held stable while `tvalid && !tready`.
  - An entry is popped only on `tvalid && tready`.
  - Simultaneous push and pop while full is allowed and is not an overflow.
- Pulses (`frame_ok`, `frame_err`, `overflow`) assert in the cycle after the causing input byte.

## Structure
- Package `manchester_pkg` holds `FLAG`, `ESC`, `PREAMBLE`, `ESC_XOR` (8'h20) and the state enum, shared with `manchester_escape`/`manchester_preamble`.
- Sub-module `axis_sync_fifo`:
  - Width 10 (`{user, last, data}`), depth `DEPTH`, FWFT.
  - Outputs `full`/`empty`.
  - Reusable on the transmit side.
- Top module holds the FSM, hold register, length counter and terminator-pending logic.

## Test plan
- **Clean frame:** 55 55 55 55 7E 01 02 03 7E, `tready=1` → out 01, 02, 03(`last`), `user=0` throughout; one `frame_ok`.
- **Escaping:** 7E 7D 5E 7D 5D 7E → out 7E, 7D(`last`); no error.
- **ESC+FLAG abort:** 7E 11 22 7D 7E, then 55 7E 33 7E → out 11, 00(`last`,`user`), 33(`last`); `frame_err` once, `frame_ok` once.
- **Overflow:** `DEPTH=4`, `tready=0`, frame 7E 01..07 7E, then `tready=1` → out 01 02 03 04, then 00(`last`,`user`); `overflow` pulses once; following frame 7E AA 7E → AA(`last`).
- **Length and empty frames:** `MAX_LEN=2`, 7E 7E 7E 01 02 03 7E 7E 09 7E → out 01, 00(`last`,`user`), then 09(`last`); no output for the empty flags.
- **Reset mid-frame:** `aresetn` low after 7E 01 02 for 3 cycles → all outputs 0, FIFO empty; next 7E 05 7E → 05(`last`) only.
